pc_gen: RTL and testbench
=========================

# pc_gen

Parametrised program-counter generator for the fetch stage. It holds the architectural fetch PC and presents it to instruction fetch over a valid/ready handshake. The next PC is selected by priority among trap entry, resolved-branch redirect, return-address-stack (RAS) prediction and sequential increment. It replaces the fixed 32-bit single-step counter and adds a reset vector, alignment checking and a RAS of configurable depth.

## Interface
Parameters:
- XLEN, 32: PC width in bits.
- RESET_VECTOR, 0: PC value loaded on reset; must be ALIGN-aligned.
- ALIGN, 4: instruction alignment in bytes; legal values are 2 and 4. It is also the sequential increment.
- RAS_DEPTH, 4: RAS entries; power of two, at least 2.

Ports:
- Clocking: reset rst, asynchronous, active-low; clock clk.
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- fetch_valid  out  1  pc is valid for fetch
- fetch_ready  in  1  fetch accepts pc this cycle
- pc  out  XLEN  current fetch PC (registered)
- redirect_valid  in  1  resolved branch/jump redirect
- redirect_target  in  XLEN  redirect destination
- trap_valid  in  1  trap entry request
- trap_vector  in  XLEN  trap handler address
- ras_push  in  1  fetched instruction is a call
- ras_push_addr  in  XLEN  return address to push
- ras_pop  in  1  fetched instruction is a return; predict from RAS
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- misaligned  out  1  one-cycle pulse: redirect target was misaligned and was dropped

## Operation
- A fetch is accepted when fetch_valid and fetch_ready are both 1. All RAS and sequential actions require an accepted fetch.
- Next-PC priority, evaluated every cycle:
  - trap_valid: pc <= trap_vector with the low $clog2(ALIGN) bits forced to 0. RAS is flushed (count=0). Applied regardless of fetch_ready.
  - redirect_valid with aligned target: pc <= redirect_target. RAS unchanged. Applied regardless of fetch_ready.
  - redirect_valid with misaligned target: pc, RAS and valid are unchanged, and misaligned=1 on the next cycle. The request still outranks the lower-priority actions below, so nothing else happens that cycle.
  - Accepted fetch with ras_pop and count>0: pc <= RAS top and count decrements.
  - Accepted fetch with ras_pop and count=0: pc <= pc+ALIGN (fallback).
  - Accepted fetch otherwise: pc <= pc+ALIGN.
  - No accepted fetch: pc holds.
- RAS push on an accepted fetch:
  - Not full: write the entry and increment count.
  - Full: overwrite the oldest entry (circular pointer wrap); count stays RAS_DEPTH.
- ras_push and ras_pop together on an accepted fetch: pc <= old top, top is replaced by ras_push_addr, and count is unchanged. If count=0, this acts as a push plus a sequential step.
- When trap_valid or redirect_valid is asserted, ras_push and ras_pop in the same cycle are ignored.
- Arithmetic: pc+ALIGN is modulo 2^XLEN; 0xFFFFFFFC+4 wraps to 0 for XLEN=32.
- fetch_valid is 0 in reset, becomes 1 at the first clk edge after rst deasserts, and stays 1.

## Timing
- Reset values: pc=RESET_VECTOR, fetch_valid=0, ras_count=0, misaligned=0. RAS pointer is 0; entry contents are don't-care.
- Reset mid-operation: asynchronous, so all outputs take reset values immediately without waiting for a clock edge. The RAS is emptied.
- Latency: any redirect, trap or increment decided in cycle N is visible on pc in cycle N+1. There is no combinational path from inputs to pc.
- misaligned is registered and high for exactly one cycle per offending request.
- With fetch_ready held at 1 and no other events, pc advances by ALIGN every cycle.

## Test plan
- Reset and stream, XLEN=32, RESET_VECTOR=0x1000, ALIGN=4:
  - Release rst and hold fetch_ready=1.
  - Required: fetch_valid rises after the first edge, pc reads 0x1000, 0x1004, 0x1008. With fetch_ready=0, pc holds.
- Priority: in one cycle assert trap_valid (vector 0x203), redirect_valid (target 0x3000) and ras_pop.
  - Required: next pc=0x200, ras_count=0.
- Misaligned redirect: redirect_target=0x3002 with ALIGN=4.
  - Required: pc unchanged, misaligned=1 for exactly one cycle.
  - Repeat with ALIGN=2: pc=0x3002 and no pulse.
- RAS overflow with RAS_DEPTH=4:
  - Push A,B,C,D,E, then pop ×5.
  - Required: ras_count saturates at 4; pops give pc=E,D,C,B; the fifth pop gives pc=prev+4 and count stays 0.
- Simultaneous push+pop with top=0x500:
  - Required: pc=0x500, top becomes ras_push_addr, count unchanged.
- Wrap and async reset:
  - Set pc=0xFFFFFFFC via redirect and step once. Required: pc=0x0.
  - Assert rst between edges. Required: pc=RESET_VECTOR and fetch_valid=0 immediately.

Source files
------------

// File: rtl/pc_gen_if.sv
// Fetch-side bundle for the PC generator: fetch handshake, redirect/trap requests and RAS hints.
// The master modport is the PC generator and the slave modport is the fetch/branch side.
interface pc_gen_if #(
    parameter int XLEN = 32,
    parameter int CW   = 3
) ();
    logic            fetch_valid;
    logic            fetch_ready;
    logic [XLEN-1:0] pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_target;
    logic            trap_valid;
    logic [XLEN-1:0] trap_vector;
    logic            ras_push;
    logic [XLEN-1:0] ras_push_addr;
    logic            ras_pop;
    logic [CW-1:0]   ras_count;
    logic            misaligned;

    modport master (
        output fetch_valid, pc, ras_count, misaligned,
        input  fetch_ready, redirect_valid, redirect_target, trap_valid, trap_vector,
               ras_push, ras_push_addr, ras_pop
    );

    modport slave (
        input  fetch_valid, pc, ras_count, misaligned,
        output fetch_ready, redirect_valid, redirect_target, trap_valid, trap_vector,
               ras_push, ras_push_addr, ras_pop
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch PC generator: trap > redirect > RAS prediction > sequential step, with a
// circular return-address stack that overwrites its oldest entry when full.
module pc_gen #(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter int                ALIGN        = 4,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic      clk,
    input  logic      rst,
    pc_gen_if.master  bus
);
    localparam int              PW         = $clog2(RAS_DEPTH);
    localparam int              CW         = PW + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ALIGN - 1);
    localparam logic [XLEN-1:0] STEP       = XLEN'(ALIGN);
    localparam logic [CW-1:0]   FULL       = CW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            misaligned_q, misaligned_d;
    logic [CW-1:0]   ras_cnt_q, ras_cnt_d;
    logic [PW-1:0]   ras_ptr_q, ras_ptr_d;
    logic [XLEN-1:0] ras_mem_q [RAS_DEPTH];
    logic [XLEN-1:0] ras_mem_d [RAS_DEPTH];

    logic            accept;
    logic            ras_empty;
    logic            ras_full;
    logic            redir_mis;
    logic [PW-1:0]   top_idx;
    logic [XLEN-1:0] ras_top;

    // ras_ptr_q is the next write slot; the top entry sits just below it.
    assign accept    = fetch_valid_q & bus.fetch_ready;
    assign ras_empty = (ras_cnt_q == '0);
    assign ras_full  = (ras_cnt_q == FULL);
    assign redir_mis = (bus.redirect_target & ALIGN_MASK) != '0;
    assign top_idx   = ras_ptr_q - PW'(1);
    assign ras_top   = ras_mem_q[top_idx];

    always_comb begin
        pc_d          = pc_q;
        fetch_valid_d = 1'b1;
        misaligned_d  = 1'b0;
        ras_cnt_d     = ras_cnt_q;
        ras_ptr_d     = ras_ptr_q;
        ras_mem_d     = ras_mem_q;

        if (bus.trap_valid) begin
            pc_d      = bus.trap_vector & ~ALIGN_MASK;
            ras_cnt_d = '0;
            ras_ptr_d = '0;
        end else if (bus.redirect_valid) begin
            if (redir_mis) begin
                misaligned_d = 1'b1;
            end else begin
                pc_d = bus.redirect_target;
            end
        end else if (accept) begin
            pc_d = pc_q + STEP;
            if (bus.ras_pop && !ras_empty) begin
                pc_d = ras_top;
            end
            if (bus.ras_push && bus.ras_pop && !ras_empty) begin
                ras_mem_d[top_idx] = bus.ras_push_addr;
            end else if (bus.ras_pop && !ras_empty) begin
                ras_ptr_d = top_idx;
                ras_cnt_d = ras_cnt_q - CW'(1);
            end else if (bus.ras_push) begin
                // When full the write slot holds the oldest entry, so it is overwritten.
                ras_mem_d[ras_ptr_q] = bus.ras_push_addr;
                ras_ptr_d            = ras_ptr_q + PW'(1);
                if (!ras_full) begin
                    ras_cnt_d = ras_cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            misaligned_q  <= 1'b0;
            ras_cnt_q     <= '0;
            ras_ptr_q     <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_q[i] <= '0;
            end
        end else begin
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            misaligned_q  <= misaligned_d;
            ras_cnt_q     <= ras_cnt_d;
            ras_ptr_q     <= ras_ptr_d;
            ras_mem_q     <= ras_mem_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.ras_count   = ras_cnt_q;
    assign bus.misaligned  = misaligned_q;
endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: two instances (ALIGN=4/depth 4 and ALIGN=2/depth 2) driven by the same
// directed and random stimulus, each compared against a stack-based reference model.
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        ready, redir_v, trap_v, push, pop;
    logic [31:0] redir_t, trap_vec, push_addr;

    pc_gen_if #(.XLEN(32), .CW(3)) if4 ();
    pc_gen_if #(.XLEN(32), .CW(2)) if2 ();

    assign if4.fetch_ready = ready;      assign if2.fetch_ready = ready;
    assign if4.redirect_valid = redir_v; assign if2.redirect_valid = redir_v;
    assign if4.redirect_target = redir_t; assign if2.redirect_target = redir_t;
    assign if4.trap_valid = trap_v;      assign if2.trap_valid = trap_v;
    assign if4.trap_vector = trap_vec;   assign if2.trap_vector = trap_vec;
    assign if4.ras_push = push;          assign if2.ras_push = push;
    assign if4.ras_push_addr = push_addr; assign if2.ras_push_addr = push_addr;
    assign if4.ras_pop = pop;            assign if2.ras_pop = pop;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h1000), .ALIGN(4), .RAS_DEPTH(4))
        dut4 (.clk(clk), .rst(rst), .bus(if4));
    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h1000), .ALIGN(2), .RAS_DEPTH(2))
        dut2 (.clk(clk), .rst(rst), .bus(if2));

    int n_chk = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: stk[0] is the oldest entry, stk[cnt-1] the top.
    logic [31:0] m_pc  [2];
    bit          m_val [2];
    bit          m_mis [2];
    int          m_cnt [2];
    logic [31:0] m_stk [2][4];
    int          m_align [2] = '{4, 2};
    int          m_depth [2] = '{4, 2};

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 32'h1000; m_val[i] = 0; m_mis[i] = 0; m_cnt[i] = 0;
        end
    endtask

    task automatic m_push(input int i, input logic [31:0] a);
        if (m_cnt[i] < m_depth[i]) begin
            m_stk[i][m_cnt[i]] = a;
            m_cnt[i]++;
        end else begin
            for (int j = 0; j < m_depth[i] - 1; j++) m_stk[i][j] = m_stk[i][j+1];
            m_stk[i][m_depth[i]-1] = a;
        end
    endtask

    task automatic m_step(input int i);
        bit acc;
        acc = m_val[i] && ready;
        m_mis[i] = 0;
        if (trap_v) begin
            m_pc[i]  = trap_vec - (trap_vec % m_align[i]);
            m_cnt[i] = 0;
        end else if (redir_v) begin
            if (redir_t % m_align[i] != 0) m_mis[i] = 1;
            else m_pc[i] = redir_t;
        end else if (acc) begin
            if (pop && m_cnt[i] > 0) begin
                m_pc[i] = m_stk[i][m_cnt[i]-1];
                if (push) m_stk[i][m_cnt[i]-1] = push_addr;
                else m_cnt[i]--;
            end else begin
                if (push) m_push(i, push_addr);
                m_pc[i] = m_pc[i] + m_align[i];
            end
        end
        m_val[i] = 1;
    endtask

    task automatic check_all();
        chk("pc_a4", if4.pc, m_pc[0]);
        chk("valid_a4", 32'(if4.fetch_valid), 32'(m_val[0]));
        chk("cnt_a4", 32'(if4.ras_count), 32'(m_cnt[0]));
        chk("mis_a4", 32'(if4.misaligned), 32'(m_mis[0]));
        chk("pc_a2", if2.pc, m_pc[1]);
        chk("valid_a2", 32'(if2.fetch_valid), 32'(m_val[1]));
        chk("cnt_a2", 32'(if2.ras_count), 32'(m_cnt[1]));
        chk("mis_a2", 32'(if2.misaligned), 32'(m_mis[1]));
    endtask

    task automatic cycle();
        m_step(0);
        m_step(1);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        ready = 0; redir_v = 0; trap_v = 0; push = 0; pop = 0;
        redir_t = 0; trap_vec = 0; push_addr = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        #1;
        m_reset();
        chk("async_pc", if4.pc, 32'h1000);
        chk("async_valid", 32'(if4.fetch_valid), 32'd0);
        chk("async_cnt", 32'(if4.ras_count), 32'd0);
        check_all();
        #2 rst = 1;
    endtask

    logic [31:0] prev;

    initial begin
        idle();
        m_reset();
        @(negedge clk);
        check_all();
        rst = 1;

        // Stream, then hold
        ready = 1;
        cycle(); chk("first_valid", 32'(if4.fetch_valid), 32'd1);
        chk("first_pc", if4.pc, 32'h1000);
        cycle(); chk("seq1", if4.pc, 32'h1004);
        cycle(); chk("seq2", if4.pc, 32'h1008);
        ready = 0;
        cycle(); cycle(); chk("hold", if4.pc, 32'h1008);

        // RAS overflow: push A..E, pop x5
        ready = 1; push = 1;
        for (int k = 0; k < 5; k++) begin
            push_addr = 32'hA00 + 32'(k) * 32'h100;
            cycle();
        end
        chk("ras_sat", 32'(if4.ras_count), 32'd4);
        push = 0; pop = 1;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("ras_pop", if4.pc, 32'hE00 - 32'(k) * 32'h100);
        end
        cycle();
        chk("pop_empty_pc", if4.pc, 32'hB04);
        chk("pop_empty_cnt", 32'(if4.ras_count), 32'd0);

        // Simultaneous push+pop
        pop = 0; push = 1; push_addr = 32'h500; cycle();
        pop = 1; push_addr = 32'h777; cycle();
        chk("pp_pc", if4.pc, 32'h500);
        chk("pp_cnt", 32'(if4.ras_count), 32'd1);
        push = 0; cycle();
        chk("pp_newtop", if4.pc, 32'h777);

        // Priority: trap beats redirect and pop
        pop = 0; push = 1; push_addr = 32'h111; cycle();
        push = 0; pop = 1; trap_v = 1; trap_vec = 32'h203; redir_v = 1; redir_t = 32'h3000;
        cycle();
        chk("trap_pc", if4.pc, 32'h200);
        chk("trap_cnt", 32'(if4.ras_count), 32'd0);
        chk("trap_pc_a2", if2.pc, 32'h202);

        // Misaligned redirect
        idle(); redir_v = 1; redir_t = 32'h3002;
        prev = if4.pc;
        cycle();
        chk("mis_pc", if4.pc, prev);
        chk("mis_pulse", 32'(if4.misaligned), 32'd1);
        chk("a2_redir", if2.pc, 32'h3002);
        chk("a2_nopulse", 32'(if2.misaligned), 32'd0);
        redir_v = 0;
        cycle();
        chk("mis_once", 32'(if4.misaligned), 32'd0);

        // Wrap
        redir_v = 1; redir_t = 32'hFFFF_FFFC; cycle();
        redir_v = 0; ready = 1; cycle();
        chk("wrap", if4.pc, 32'h0);

        do_reset();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            ready     = ($urandom_range(3) != 0);
            trap_v    = ($urandom_range(31) == 0);
            trap_vec  = $urandom;
            redir_v   = ($urandom_range(9) == 0);
            redir_t   = ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFF);
            push      = ($urandom_range(3) == 0);
            pop       = ($urandom_range(3) == 0);
            push_addr = $urandom & 32'hFFFF_FFFE;
            cycle();
            if ($urandom_range(199) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
